// File: rtl/param_moore_seq_detector_if.sv
// Serial bit-stream bundle for param_moore_seq_detector.
//   en        : sample qualifier (master -> slave)
//   j         : serial data bit (master -> slave)
//   clr_cnt   : synchronous clear of the match counter (master -> slave)
//   w         : Moore match flag (slave -> master)
//   match_cnt : saturating match count, CNT_W bits (slave -> master)
interface param_moore_seq_detector_if #(
    parameter int CNT_W = 8
);
    logic             en;
    logic             j;
    logic             clr_cnt;
    logic             w;
    logic [CNT_W-1:0] match_cnt;

    modport master (
        output en, j, clr_cnt,
        input  w, match_cnt
    );

    modport slave (
        input  en, j, clr_cnt,
        output w, match_cnt
    );
endinterface

// File: rtl/param_moore_seq_detector.sv
// Parametrised Moore serial sequence detector with a saturating match counter.
//   clk : rising-edge clock
//   rst : asynchronous active-high reset
//   bus : slave side of param_moore_seq_detector_if (en, j, clr_cnt in; w, match_cnt out)
//
// State k (0..PATTERN_LEN) means the last k consumed bits equal the first k
// pattern bits. The state is a plain vector rather than an enum because the
// number of states follows PATTERN_LEN.
//   state        | meaning
//   0            | no pattern prefix matched
//   1..LEN-1     | that many leading pattern bits matched
//   LEN          | accept, w=1
//   > LEN        | unused encoding, returns to 0 on the next edge
module param_moore_seq_detector #(
    parameter int                     PATTERN_LEN = 4,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 4'b1011,
    parameter bit                     OVERLAP     = 1'b1,
    parameter int                     CNT_W       = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    param_moore_seq_detector_if.slave bus
);

    localparam int                SW      = (PATTERN_LEN < 2) ? 1 : $clog2(PATTERN_LEN + 1);
    localparam int                ROWS    = PATTERN_LEN + 1;
    localparam logic [SW-1:0]     ACCEPT  = SW'(PATTERN_LEN);
    localparam logic [CNT_W-1:0]  CNT_MAX = {CNT_W{1'b1}};

    // Next-state table, entry (2*k + j): length of the longest pattern prefix
    // that is a suffix of (first k pattern bits, then j). A matching j yields
    // k+1; row PATTERN_LEN gives the overlapping continuation after an accept.
    function automatic logic [2*ROWS*SW-1:0] build_table();
        logic [2*ROWS*SW-1:0] t;
        int   best;
        int   lim;
        int   p;
        logic ok;
        logic c;
        t = '0;
        for (int k = 0; k <= PATTERN_LEN; k++) begin
            for (int b = 0; b < 2; b++) begin
                best = 0;
                lim  = (k + 1 < PATTERN_LEN) ? k + 1 : PATTERN_LEN;
                for (int m = 1; m <= lim; m++) begin
                    ok = 1'b1;
                    for (int i = 0; i < m; i++) begin
                        p = k + 1 - m + i;
                        if (p < k) c = PATTERN[PATTERN_LEN-1-p];
                        else       c = b[0];
                        if (c != PATTERN[PATTERN_LEN-1-i]) ok = 1'b0;
                    end
                    if (ok) best = m;
                end
                t[(2*k+b)*SW +: SW] = best[SW-1:0];
            end
        end
        return t;
    endfunction

    localparam logic [2*ROWS*SW-1:0] NEXT_TBL = build_table();

    logic [SW-1:0]    state_q;
    logic [SW-1:0]    nxt;
    logic             w_q;
    logic [CNT_W-1:0] cnt_q;
    logic             hit;
    int               row;

    always_comb begin
        nxt = state_q;
        row = 0;
        if (state_q > ACCEPT) begin
            nxt = '0;
        end else if (bus.en) begin
            // Non-overlapping mode restarts from scratch after an accept.
            if (state_q == ACCEPT && !OVERLAP) row = 0;
            else                               row = int'(state_q);
            nxt = NEXT_TBL[(2*row + int'(bus.j))*SW +: SW];
        end
    end

    assign hit = bus.en && (nxt == ACCEPT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= '0;
            w_q     <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= nxt;
            w_q     <= (nxt == ACCEPT);
            if (bus.clr_cnt) begin
                cnt_q <= hit ? CNT_W'(1) : '0;
            end else if (hit && cnt_q != CNT_MAX) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign bus.w         = w_q;
    assign bus.match_cnt = cnt_q;

endmodule

// File: tb/tb_param_moore_seq_detector.sv
module tb_param_moore_seq_detector;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    param_moore_seq_detector_if #(.CNT_W(8)) if_a ();
    param_moore_seq_detector_if #(.CNT_W(8)) if_b ();
    param_moore_seq_detector_if #(.CNT_W(8)) if_c ();
    param_moore_seq_detector_if #(.CNT_W(8)) if_d ();
    param_moore_seq_detector_if #(.CNT_W(2)) if_e ();

    // a: defaults, b: non-overlapping 1011, c/d: 111 overlapping/non, e: single-bit, 2-bit counter
    param_moore_seq_detector u_a (.clk(clk), .rst(rst), .bus(if_a.slave));
    param_moore_seq_detector #(.OVERLAP(1'b0)) u_b (.clk(clk), .rst(rst), .bus(if_b.slave));
    param_moore_seq_detector #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b1))
        u_c (.clk(clk), .rst(rst), .bus(if_c.slave));
    param_moore_seq_detector #(.PATTERN_LEN(3), .PATTERN(3'b111), .OVERLAP(1'b0))
        u_d (.clk(clk), .rst(rst), .bus(if_d.slave));
    param_moore_seq_detector #(.PATTERN_LEN(1), .PATTERN(1'b1), .CNT_W(2))
        u_e (.clk(clk), .rst(rst), .bus(if_e.slave));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        int dut;
        int en;
        int j;
        int clr;
        int exp_w;
        int exp_cnt;
        int exp_state;   // -1: not checked (state only visible on dut 0)
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input int d, input int en, input int j, input int clr);
        case (d)
            0: begin if_a.en = en[0]; if_a.j = j[0]; if_a.clr_cnt = clr[0]; end
            1: begin if_b.en = en[0]; if_b.j = j[0]; if_b.clr_cnt = clr[0]; end
            2: begin if_c.en = en[0]; if_c.j = j[0]; if_c.clr_cnt = clr[0]; end
            3: begin if_d.en = en[0]; if_d.j = j[0]; if_d.clr_cnt = clr[0]; end
            default: begin if_e.en = en[0]; if_e.j = j[0]; if_e.clr_cnt = clr[0]; end
        endcase
    endtask

    function automatic int get_w(input int d);
        case (d)
            0: return int'(if_a.w);
            1: return int'(if_b.w);
            2: return int'(if_c.w);
            3: return int'(if_d.w);
            default: return int'(if_e.w);
        endcase
    endfunction

    function automatic int get_cnt(input int d);
        case (d)
            0: return int'(if_a.match_cnt);
            1: return int'(if_b.match_cnt);
            2: return int'(if_c.match_cnt);
            3: return int'(if_d.match_cnt);
            default: return int'(if_e.match_cnt);
        endcase
    endfunction

    // Drive between edges, consume on the rising edge, sample 1 time unit later.
    task automatic step(input int d, input int en, input int j, input int clr);
        @(negedge clk);
        drive(d, en, j, clr);
        @(posedge clk);
        #1;
        drive(d, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst   = 1'b1;
        for (int d = 0; d < 5; d++) drive(d, 0, 0, 0);

        // 1011 overlapping: stream 1,0,1,1,0,1,1
        vecs.push_back('{0, 1, 1, 0, 0, 0, 1});
        vecs.push_back('{0, 1, 0, 0, 0, 0, 2});
        vecs.push_back('{0, 1, 1, 0, 0, 0, 3});
        vecs.push_back('{0, 1, 1, 0, 1, 1, 4});
        vecs.push_back('{0, 1, 0, 0, 0, 1, 2});
        vecs.push_back('{0, 1, 1, 0, 0, 1, 3});
        vecs.push_back('{0, 1, 1, 0, 1, 2, 4});
        // 1011 non-overlapping, same stream
        vecs.push_back('{1, 1, 1, 0, 0, 0, -1});
        vecs.push_back('{1, 1, 0, 0, 0, 0, -1});
        vecs.push_back('{1, 1, 1, 0, 0, 0, -1});
        vecs.push_back('{1, 1, 1, 0, 1, 1, -1});
        vecs.push_back('{1, 1, 0, 0, 0, 1, -1});
        vecs.push_back('{1, 1, 1, 0, 0, 1, -1});
        vecs.push_back('{1, 1, 1, 0, 0, 1, -1});
        // 111 overlapping, five 1s
        for (int i = 0; i < 5; i++)
            vecs.push_back('{2, 1, 1, 0, (i >= 2) ? 1 : 0, (i >= 2) ? i - 1 : 0, -1});
        // 111 non-overlapping, five 1s
        for (int i = 0; i < 5; i++)
            vecs.push_back('{3, 1, 1, 0, (i == 2) ? 1 : 0, (i >= 2) ? 1 : 0, -1});
        // single-bit pattern, 2-bit counter saturation, then clears
        vecs.push_back('{4, 1, 1, 0, 1, 1, -1});
        vecs.push_back('{4, 1, 1, 0, 1, 2, -1});
        vecs.push_back('{4, 1, 1, 0, 1, 3, -1});
        vecs.push_back('{4, 1, 1, 0, 1, 3, -1});
        vecs.push_back('{4, 1, 1, 0, 1, 3, -1});
        vecs.push_back('{4, 1, 1, 1, 1, 1, -1});
        vecs.push_back('{4, 1, 0, 1, 0, 0, -1});

        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int d = 0; d < 5; d++) begin
            chk($sformatf("reset_w[%0d]", d), get_w(d), 0);
            chk($sformatf("reset_cnt[%0d]", d), get_cnt(d), 0);
        end

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].dut, vecs[i].en, vecs[i].j, vecs[i].clr);
            chk($sformatf("vec%0d_w", i), get_w(vecs[i].dut), vecs[i].exp_w);
            chk($sformatf("vec%0d_cnt", i), get_cnt(vecs[i].dut), vecs[i].exp_cnt);
            if (vecs[i].exp_state >= 0)
                chk($sformatf("vec%0d_state", i), int'(u_a.state_q), vecs[i].exp_state);
        end

        // en=0 holds progress while j toggles
        do_reset();
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, i % 2, 0);
            chk($sformatf("hold%0d_state", i), int'(u_a.state_q), 3);
            chk($sformatf("hold%0d_w", i), get_w(0), 0);
        end
        step(0, 1, 1, 0);
        chk("hold_final_w", get_w(0), 1);
        chk("hold_final_cnt", get_cnt(0), 1);

        // asynchronous reset mid-sequence
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        chk("pre_rst_state", int'(u_a.state_q), 3);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_state", int'(u_a.state_q), 0);
        chk("async_rst_cnt", get_cnt(0), 0);
        chk("async_rst_w", get_w(0), 0);
        @(negedge clk);
        rst = 1'b0;
        step(0, 1, 1, 0);
        chk("post_rst_w", get_w(0), 0);
        chk("post_rst_state", int'(u_a.state_q), 1);
        chk("post_rst_cnt", get_cnt(0), 0);

        // clr_cnt leaves the state alone: 1 -> 10 is state 2
        step(0, 1, 1, 0);
        step(0, 1, 0, 0);
        step(0, 1, 1, 0);
        step(0, 1, 1, 0);
        chk("pre_clr_cnt", get_cnt(0), 1);
        step(0, 1, 0, 1);
        chk("clr_state", int'(u_a.state_q), 2);
        chk("clr_cnt", get_cnt(0), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
